debug_frame_tx: RTL and testbench
=================================

# debug_frame_tx

Parametrised snapshot serializer between the debug unit and `uart_tx`. On a start pulse it captures an arbitrary-width debug frame, such as pipeline latch contents or control flags, and streams it byte by byte to the UART transmitter. The stream is a header byte, a length byte, then the data bytes, most significant first. It generalises the fixed-width byte sequencing in `uart_interface` to any frame width, and adds an optional integrity byte.

## Interface
Parameters:
- `NB_DATA`, 8, UART byte width; fixed at 8.
- `NB_FRAME`, 144, snapshot width in bits, 1..2040.
- `HEADER`, 8'hA5, sync byte sent first.
- Derived (localparam): `N_BYTES` = ceil(NB_FRAME/8), 1..255.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_start` in 1: capture request; sampled only in IDLE.
- `i_frame` in NB_FRAME: snapshot data; sampled on the accepting edge.
- `i_txDone` in 1: one-cycle pulse from `uart_tx` when the current byte has completed.
- `o_tx_start` out 1: one-cycle pulse that launches a byte in `uart_tx`.
- `o_data` out 8: byte presented to `uart_tx`.
- `o_busy` out 1: high from acceptance through the FINISH cycle.
- `o_done` out 1: one-cycle pulse after the last byte's `i_txDone`.

## Operation
- Frame capture:
  - The frame is copied into an internal shadow register.
  - Bits above NB_FRAME, up to 8·N_BYTES, are zero-padded at the MSB end.
  - `i_frame` may change freely after capture.
- Byte sequence:
  - `HEADER`, then `N_BYTES`, then shadow bytes from MS to LS.
  - With the macro enabled, a checksum byte follows.
- Byte index counter:
  - Width is clog2(N_BYTES+3).
  - It selects the byte through a mux on the shadow register, not a shift.
- States:
  - IDLE: all outputs 0. `i_start`=1 → capture, index=0, go to ISSUE. `i_txDone` is ignored.
  - ISSUE (1 cycle): `o_tx_start`=1, `o_data`=byte[index], go to WAIT.
  - WAIT: `o_data` holds. On `i_txDone`:
    - If index is the last byte, go to FINISH.
    - Otherwise index+1 and go to ISSUE.
  - FINISH (1 cycle): `o_done`=1, go to IDLE.
- Boundary cases:
  - `i_start` in any state other than IDLE is ignored; it is neither queued nor re-captured.
  - `i_txDone` in ISSUE, FINISH or IDLE is ignored.
  - Reset mid-frame: outputs are forced to reset values immediately and the state goes to IDLE. No partial `o_done` is produced. The shadow register is cleared to 0.
  - NB_FRAME multiple of 8: no padding.
  - N_BYTES=1 is legal: 3 bytes are sent (4 with the checksum).
- Reset values: `o_tx_start`=0, `o_data`=8'h00, `o_busy`=0, `o_done`=0, state IDLE, index 0.

## Timing
- All outputs are registered.
- The edge that samples `i_start`=1 in IDLE is edge E. From E+1:
  - `o_busy`=1.
  - `o_tx_start`=1 with `o_data`=HEADER, held for exactly 1 cycle.
- `i_txDone` sampled at edge T: the next `o_tx_start` is high in cycle T+1. Inter-byte overhead is therefore 1 cycle beyond the UART frame time.
- After the last byte's `i_txDone` at edge T:
  - `o_done`=1 and `o_busy`=1 in cycle T+1.
  - Both are 0 in T+2.
  - A new `i_start` is accepted at the T+2 edge at the earliest.
- Total cycles, with W = UART wait per byte: (N_BYTES+2[+1])·(1+W) + 1.

## Configuration
- `DEBUG_FRAME_CHECKSUM_EN` defined:
  - After the last data byte, one extra byte is sent: the XOR of all N_BYTES data bytes, excluding the header and length bytes.
  - It is accumulated as bytes issue; no combinational XOR across the full frame.
- `DEBUG_FRAME_CHECKSUM_EN` undefined:
  - The sequence ends at the last data byte.
  - No accumulator logic is generated.
- The length byte always equals N_BYTES regardless of the macro.

## Test plan
- NB_FRAME=16, `i_frame`=16'h1234, `uart_tx` model with `i_txDone` 5 cycles after each `o_tx_start`:
  - Without the macro: bytes A5,02,12,34 then one `o_done` pulse.
  - With the macro: bytes A5,02,12,34,26.
- NB_FRAME=12, `i_frame`=12'hABC → bytes A5,02,0A,BC. Padding is zero.
- `i_start` pulsed again during WAIT with different `i_frame` → no effect; the original bytes complete and exactly one `o_done` is produced.
- `i_frame` changed the cycle after acceptance → transmitted bytes still equal the captured value.
- `i_rst_n` low during the 3rd byte's WAIT → all outputs 0 asynchronously. After release, `i_start` with 16'h00FF → full A5,02,00,FF sequence from the header.
- Stray `i_txDone` pulses in IDLE and ISSUE → no index advance and no extra `o_tx_start`. `o_tx_start` count per frame equals N_BYTES+2 (N_BYTES+3 with the macro).

Source files
------------

// File: rtl/debug_frame_tx.sv
// Snapshot serializer: header, length, then frame bytes MS-first toward uart_tx.
// Define DEBUG_FRAME_CHECKSUM_EN to append an XOR checksum of the data bytes.
module debug_frame_tx #(
  parameter int              NB_DATA  = 8,
  parameter int              NB_FRAME = 144,
  parameter logic [NB_DATA-1:0] HEADER = 8'hA5
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [NB_FRAME-1:0] i_frame,
  input  logic                i_txDone,
  output logic                o_tx_start,
  output logic [NB_DATA-1:0]  o_data,
  output logic                o_busy,
  output logic                o_done
);

  localparam int N_BYTES = (NB_FRAME + 7) / 8;
  localparam int SH_W    = 8 * N_BYTES;
  localparam int IDX_W   = $clog2(N_BYTES + 3);
`ifdef DEBUG_FRAME_CHECKSUM_EN
  localparam int N_SEQ   = N_BYTES + 3;
`else
  localparam int N_SEQ   = N_BYTES + 2;
`endif
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_SEQ - 1);
  localparam logic [NB_DATA-1:0] LEN_BYTE = NB_DATA'(N_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   next_idx;
  logic [SH_W-1:0]    shadow;
  logic [NB_DATA-1:0] next_byte;
`ifdef DEBUG_FRAME_CHECKSUM_EN
  localparam logic [IDX_W-1:0] FIRST_DATA = IDX_W'(2);
  localparam logic [IDX_W-1:0] LAST_DATA  = IDX_W'(N_BYTES + 1);
  logic [NB_DATA-1:0] csum;
`endif

  // Byte for the following sequence slot; header is loaded directly on accept.
  always_comb begin
    next_idx  = idx + 1'b1;
    next_byte = '0;
    if (next_idx == IDX_W'(1))
      next_byte = LEN_BYTE;
    for (int unsigned k = 0; k < N_BYTES; k++) begin
      if (next_idx == IDX_W'(k + 2))
        next_byte = shadow[8*(N_BYTES-1-k) +: 8];
    end
`ifdef DEBUG_FRAME_CHECKSUM_EN
    if (next_idx == LAST_IDX)
      next_byte = csum;
`endif
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      shadow     <= '0;
      o_tx_start <= 1'b0;
      o_data     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
`ifdef DEBUG_FRAME_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            shadow     <= SH_W'(i_frame);
            idx        <= '0;
            o_data     <= HEADER;
            o_tx_start <= 1'b1;
            o_busy     <= 1'b1;
            state      <= ISSUE;
`ifdef DEBUG_FRAME_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end
        ISSUE: begin
          o_tx_start <= 1'b0;
          state      <= WAIT;
`ifdef DEBUG_FRAME_CHECKSUM_EN
          // Fold each data byte in as it goes out, avoiding a wide XOR tree.
          if (idx >= FIRST_DATA && idx <= LAST_DATA)
            csum <= csum ^ o_data;
`endif
        end
        WAIT: begin
          if (i_txDone) begin
            if (idx == LAST_IDX) begin
              o_data <= '0;
              o_done <= 1'b1;
              state  <= FINISH;
            end else begin
              idx        <= next_idx;
              o_data     <= next_byte;
              o_tx_start <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        FINISH: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          o_data <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench for debug_frame_tx: 16-bit and 12-bit frames against a
// uart_tx model that returns i_txDone five cycles after each o_tx_start.
module tb_debug_frame_tx;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start16, start12;
  logic [15:0] frame16;
  logic [11:0] frame12;
  logic        txd16, txd12, mdl16, mdl12, stray16;
  logic [3:0]  cnt16, cnt12;
  logic        tx16, tx12, busy16, busy12, done16, done12;
  logic [7:0]  d16, d12;

  int checks = 0;
  int errors = 0;
  bq_t q16, q12;
  int ndone16 = 0;
  int ndone12 = 0;

  always #5 clk = ~clk;

  debug_frame_tx #(.NB_DATA(8), .NB_FRAME(16), .HEADER(8'hA5)) dut16 (
    .clk(clk), .i_rst_n(rst_n), .i_start(start16), .i_frame(frame16),
    .i_txDone(txd16), .o_tx_start(tx16), .o_data(d16), .o_busy(busy16), .o_done(done16));

  debug_frame_tx #(.NB_DATA(8), .NB_FRAME(12), .HEADER(8'hA5)) dut12 (
    .clk(clk), .i_rst_n(rst_n), .i_start(start12), .i_frame(frame12),
    .i_txDone(txd12), .o_tx_start(tx12), .o_data(d12), .o_busy(busy12), .o_done(done12));

  assign txd16 = mdl16 | stray16;
  assign txd12 = mdl12;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt16 <= '0; mdl16 <= 1'b0; cnt12 <= '0; mdl12 <= 1'b0;
    end else begin
      mdl16 <= (cnt16 == 4'd1);
      if (tx16) cnt16 <= 4'd5; else if (cnt16 != 0) cnt16 <= cnt16 - 4'd1;
      mdl12 <= (cnt12 == 4'd1);
      if (tx12) cnt12 <= 4'd5; else if (cnt12 != 0) cnt12 <= cnt12 - 4'd1;
    end
  end

  always @(negedge clk) begin
    if (tx16) q16.push_back(d16);
    if (tx12) q12.push_back(d12);
    if (done16) ndone16++;
    if (done12) ndone12++;
  end

  function automatic bq_t mk(input logic [7:0] hi, input logic [7:0] lo);
    bq_t r;
    r.push_back(8'hA5); r.push_back(8'h02); r.push_back(hi); r.push_back(lo);
`ifdef DEBUG_FRAME_CHECKSUM_EN
    r.push_back(hi ^ lo);
`endif
    return r;
  endfunction

  task automatic wait_done16(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done16) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done12(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done12) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start16 = 1'b0; start12 = 1'b0; stray16 = 1'b0;
    frame16 = '0; frame12 = '0;
    repeat (3) @(negedge clk);
    checks++; if (tx16 !== 1'b0)   begin errors++; $display("FAIL reset_tx16 got %b exp 0", tx16); end
    checks++; if (d16 !== 8'h00)   begin errors++; $display("FAIL reset_data16 got %h exp 00", d16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy16 got %b exp 0", busy16); end
    checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL reset_done16 got %b exp 0", done16); end
    checks++; if (tx12 !== 1'b0)   begin errors++; $display("FAIL reset_tx12 got %b exp 0", tx12); end
    checks++; if (busy12 !== 1'b0) begin errors++; $display("FAIL reset_busy12 got %b exp 0", busy12); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sequence;
    bq_t exp = mk(8'h12, 8'h34);
    bit ok;
    q16.delete(); ndone16 = 0;
    frame16 = 16'h1234; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL seq_busy_e1 got %b exp 1", busy16); end
    checks++; if (tx16 !== 1'b1)   begin errors++; $display("FAIL seq_txstart_e1 got %b exp 1", tx16); end
    checks++; if (d16 !== 8'hA5)   begin errors++; $display("FAIL seq_header_e1 got %h exp a5", d16); end
    @(negedge clk);
    checks++; if (tx16 !== 1'b0)   begin errors++; $display("FAIL seq_txstart_e2 got %b exp 0", tx16); end
    checks++; if (d16 !== 8'hA5)   begin errors++; $display("FAIL seq_hold_e2 got %h exp a5", d16); end
    wait_done16(ok);
    checks++; if (!ok) begin errors++; $display("FAIL seq_timeout got none exp o_done"); end
    checks++; if (busy16 !== 1'b1) begin errors++; $display("FAIL seq_busy_finish got %b exp 1", busy16); end
    @(negedge clk);
    checks++; if (done16 !== 1'b0 || busy16 !== 1'b0)
      begin errors++; $display("FAIL seq_after_finish got done=%b busy=%b exp 0 0", done16, busy16); end
    repeat (3) @(negedge clk);
    checks++; if (q16.size() !== exp.size()) begin errors++; $display("FAIL seq_count got %0d exp %0d", q16.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q16.size(); i++) begin
      checks++; if (q16[i] !== exp[i]) begin errors++; $display("FAIL seq_byte%0d got %h exp %h", i, q16[i], exp[i]); end
    end
    checks++; if (ndone16 !== 1) begin errors++; $display("FAIL seq_ndone got %0d exp 1", ndone16); end
  endtask

  task automatic test_padding;
    bq_t exp = mk(8'h0A, 8'hBC);
    bit ok;
    q12.delete(); ndone12 = 0;
    frame12 = 12'hABC; start12 = 1'b1;
    @(negedge clk); start12 = 1'b0;
    wait_done12(ok);
    checks++; if (!ok) begin errors++; $display("FAIL pad_timeout got none exp o_done"); end
    repeat (3) @(negedge clk);
    checks++; if (q12.size() !== exp.size()) begin errors++; $display("FAIL pad_count got %0d exp %0d", q12.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q12.size(); i++) begin
      checks++; if (q12[i] !== exp[i]) begin errors++; $display("FAIL pad_byte%0d got %h exp %h", i, q12[i], exp[i]); end
    end
    checks++; if (ndone12 !== 1) begin errors++; $display("FAIL pad_ndone got %0d exp 1", ndone12); end
  endtask

  task automatic test_restart_ignored;
    bq_t exp = mk(8'h12, 8'h34);
    bit ok;
    q16.delete(); ndone16 = 0;
    frame16 = 16'h1234; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0; frame16 = 16'h5678;
    repeat (3) @(negedge clk);
    frame16 = 16'h9ABC; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    wait_done16(ok);
    checks++; if (!ok) begin errors++; $display("FAIL restart_timeout got none exp o_done"); end
    repeat (20) @(negedge clk);
    checks++; if (q16.size() !== exp.size()) begin errors++; $display("FAIL restart_count got %0d exp %0d", q16.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q16.size(); i++) begin
      checks++; if (q16[i] !== exp[i]) begin errors++; $display("FAIL restart_byte%0d got %h exp %h", i, q16[i], exp[i]); end
    end
    checks++; if (ndone16 !== 1) begin errors++; $display("FAIL restart_ndone got %0d exp 1", ndone16); end
    checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL restart_idle_busy got %b exp 0", busy16); end
  endtask

  task automatic test_back_to_back;
    bq_t exp = mk(8'h55, 8'hAA);
    bit ok;
    q16.delete(); ndone16 = 0;
    frame16 = 16'h1234; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    wait_done16(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout1 got none exp o_done"); end
    // Hold start through FINISH; only the following edge may accept it.
    q16.delete(); frame16 = 16'h55AA; start16 = 1'b1;
    @(negedge clk);
    checks++; if (tx16 !== 1'b0 || busy16 !== 1'b0)
      begin errors++; $display("FAIL b2b_early got tx=%b busy=%b exp 0 0", tx16, busy16); end
    @(negedge clk); start16 = 1'b0;
    checks++; if (tx16 !== 1'b1 || d16 !== 8'hA5)
      begin errors++; $display("FAIL b2b_accept got tx=%b data=%h exp 1 a5", tx16, d16); end
    wait_done16(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout2 got none exp o_done"); end
    repeat (3) @(negedge clk);
    checks++; if (q16.size() !== exp.size()) begin errors++; $display("FAIL b2b_count got %0d exp %0d", q16.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q16.size(); i++) begin
      checks++; if (q16[i] !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d got %h exp %h", i, q16[i], exp[i]); end
    end
    checks++; if (ndone16 !== 2) begin errors++; $display("FAIL b2b_ndone got %0d exp 2", ndone16); end
  endtask

  task automatic test_reset_mid_frame;
    bq_t exp = mk(8'h00, 8'hFF);
    bit ok;
    bit seen = 1'b0;
    q16.delete(); ndone16 = 0;
    frame16 = 16'h1234; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q16.size() >= 3) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_timeout got %0d bytes exp 3", q16.size()); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx16 !== 1'b0 || d16 !== 8'h00 || busy16 !== 1'b0 || done16 !== 1'b0)
      begin errors++; $display("FAIL rstmid_async got tx=%b data=%h busy=%b done=%b exp 0 00 0 0", tx16, d16, busy16, done16); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (ndone16 !== 0) begin errors++; $display("FAIL rstmid_nodone got %0d exp 0", ndone16); end
    q16.delete();
    frame16 = 16'h00FF; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    wait_done16(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout2 got none exp o_done"); end
    repeat (3) @(negedge clk);
    checks++; if (q16.size() !== exp.size()) begin errors++; $display("FAIL rstmid_count got %0d exp %0d", q16.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q16.size(); i++) begin
      checks++; if (q16[i] !== exp[i]) begin errors++; $display("FAIL rstmid_byte%0d got %h exp %h", i, q16[i], exp[i]); end
    end
  endtask

  task automatic test_stray_done;
    bq_t exp = mk(8'hBE, 8'hEF);
    bit ok;
    q16.delete(); ndone16 = 0;
    stray16 = 1'b1;
    @(negedge clk); stray16 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (q16.size() !== 0 || busy16 !== 1'b0)
      begin errors++; $display("FAIL stray_idle got bytes=%0d busy=%b exp 0 0", q16.size(), busy16); end
    frame16 = 16'hBEEF; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    stray16 = 1'b1;
    @(negedge clk); stray16 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx16 && q16.size() == 2) break;
    end
    stray16 = 1'b1;
    @(negedge clk); stray16 = 1'b0;
    wait_done16(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stray_timeout got none exp o_done"); end
    repeat (3) @(negedge clk);
    checks++; if (q16.size() !== exp.size()) begin errors++; $display("FAIL stray_count got %0d exp %0d", q16.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q16.size(); i++) begin
      checks++; if (q16[i] !== exp[i]) begin errors++; $display("FAIL stray_byte%0d got %h exp %h", i, q16[i], exp[i]); end
    end
    checks++; if (ndone16 !== 1) begin errors++; $display("FAIL stray_ndone got %0d exp 1", ndone16); end
  endtask

  initial begin
    test_reset;
    test_sequence;
    test_padding;
    test_restart_ignored;
    test_back_to_back;
    test_reset_mid_frame;
    test_stray_done;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
